// File: rtl/sega_joy_scan.sv
// Two-port DB9 scanner: drives the shared Sega select line and publishes 12-bit active-low words.
// Optional: define SEGA_SIX_BUTTON_EN to enable 6-button detection and X/Y/Z/M capture.
module sega_joy_scan #(
  parameter int CLK_DIV = 768
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        joy1_up_i,
  input  logic        joy1_down_i,
  input  logic        joy1_left_i,
  input  logic        joy1_right_i,
  input  logic        joy1_p6_i,
  input  logic        joy1_p9_i,
  input  logic        joy2_up_i,
  input  logic        joy2_down_i,
  input  logic        joy2_left_i,
  input  logic        joy2_right_i,
  input  logic        joy2_p6_i,
  input  logic        joy2_p9_i,
  output logic        joyX_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    ACT_SEL_LO,
    ACT_SEL_HI,
    ACT_SAMPLE_BASE,
    ACT_SAMPLE_MD,
    ACT_PULSE_LO,
    ACT_DETECT_SIX,
    ACT_SAMPLE_EXT,
    ACT_PUBLISH,
    ACT_IDLE
  } action_t;

  logic [11:0]      pins_raw;
  logic [11:0]      pins_meta;
  logic [11:0]      pins_sync;
  logic [15:0]      div_cnt;
  logic             tick;
  logic [7:0]       phase;
  action_t          action;
  logic             p7_q, p7_d;
  logic [1:0][11:0] shadow_q, shadow_d;
  logic [1:0]       six_q, six_d;
  logic [1:0][11:0] word_q, word_d;
  logic [1:0]       six_out_q, six_out_d;
  logic             frame_q, frame_d;

  // Per port the six bits are ordered {p9, p6, R, L, D, U}; port 1 in the low half.
  assign pins_raw = {joy2_p9_i, joy2_p6_i, joy2_right_i, joy2_left_i, joy2_down_i, joy2_up_i,
                     joy1_p9_i, joy1_p6_i, joy1_right_i, joy1_left_i, joy1_down_i, joy1_up_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pins_meta <= 12'hFFF;
      pins_sync <= 12'hFFF;
    end else begin
      pins_meta <= pins_raw;
      pins_sync <= pins_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt <= 16'd0;
      phase   <= 8'd0;
    end else if (tick) begin
      div_cnt <= 16'd0;
      phase   <= phase + 8'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_comb begin
    action = ACT_IDLE;
    case (phase)
      8'd0:    action = ACT_SEL_LO;
      8'd1:    action = ACT_SEL_HI;
      8'd2:    action = ACT_SAMPLE_BASE;
      8'd3:    action = ACT_SAMPLE_MD;
      8'd4:    action = ACT_PULSE_LO;
      8'd5:    action = ACT_DETECT_SIX;
      8'd6:    action = ACT_SAMPLE_EXT;
      8'd7:    action = ACT_PUBLISH;
      default: action = ACT_IDLE;
    endcase
  end

  // Each sample reads the pins settled under the select level driven one tick earlier.
  always_comb begin
    p7_d      = p7_q;
    shadow_d  = shadow_q;
    six_d     = six_q;
    word_d    = word_q;
    six_out_d = six_out_q;
    frame_d   = 1'b0;
    if (tick) begin
      case (action)
        ACT_SEL_LO: p7_d = 1'b0;
        ACT_SEL_HI: p7_d = 1'b1;
        ACT_SAMPLE_BASE: begin
          for (int k = 0; k < 2; k++) begin
            shadow_d[k][5:0] = pins_sync[k*6 +: 6];
            six_d[k]         = 1'b0;
          end
          p7_d = 1'b0;
        end
        ACT_SAMPLE_MD: begin
          // A Mega Drive pad grounds R and L while select is low; anything else is a plain stick.
          for (int k = 0; k < 2; k++) begin
            if (!pins_sync[k*6 + 3] && !pins_sync[k*6 + 2])
              shadow_d[k][7:6] = pins_sync[k*6 + 4 +: 2];
            else
              shadow_d[k][7:4] = {2'b11, pins_sync[k*6 + 4 +: 2]};
          end
          p7_d = 1'b1;
        end
        ACT_PULSE_LO: p7_d = 1'b0;
        ACT_DETECT_SIX: begin
`ifdef SEGA_SIX_BUTTON_EN
          for (int k = 0; k < 2; k++) begin
            if (pins_sync[k*6 +: 4] == 4'b0000)
              six_d[k] = 1'b1;
          end
`endif
          p7_d = 1'b1;
        end
        ACT_SAMPLE_EXT: begin
          for (int k = 0; k < 2; k++) begin
`ifdef SEGA_SIX_BUTTON_EN
            shadow_d[k][11:8] = six_q[k] ? pins_sync[k*6 +: 4] : 4'hF;
`else
            shadow_d[k][11:8] = 4'hF;
`endif
          end
          p7_d = 1'b0;
        end
        ACT_PUBLISH: begin
          word_d    = shadow_q;
          six_out_d = six_q;
          frame_d   = 1'b1;
          p7_d      = 1'b1;
        end
        default: p7_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      p7_q      <= 1'b1;
      shadow_q  <= {2{12'hFFF}};
      six_q     <= 2'b00;
      word_q    <= {2{12'hFFF}};
      six_out_q <= 2'b00;
      frame_q   <= 1'b0;
    end else begin
      p7_q      <= p7_d;
      shadow_q  <= shadow_d;
      six_q     <= six_d;
      word_q    <= word_d;
      six_out_q <= six_out_d;
      frame_q   <= frame_d;
    end
  end

  assign joyX_p7_o = p7_q;
  assign joy1_o    = word_q[0];
  assign joy2_o    = word_q[1];
  assign frame_o   = frame_q;
`ifdef SEGA_SIX_BUTTON_EN
  assign six1_o    = six_out_q[0];
  assign six2_o    = six_out_q[1];
`else
  assign six1_o    = 1'b0;
  assign six2_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sega_joy_scan.sv
// Bench for sega_joy_scan: behavioural Atari / 3-button / 6-button pad models on both ports.
module tb_sega_joy_scan;

  localparam int D = 4;
`ifdef SEGA_SIX_BUTTON_EN
  localparam bit SIX_EN = 1'b1;
`else
  localparam bit SIX_EN = 1'b0;
`endif

  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b1;
  logic        joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i;
  logic        joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i;
  logic        joyX_p7_o;
  logic [11:0] joy1_o, joy2_o;
  logic        six1_o, six2_o, frame_o;

  // Pad types: 0 = Atari/SMS stick (or nothing), 1 = 3-button pad, 2 = 6-button pad.
  // Buttons are active-high, laid out MXYZ SACB RLDU.
  int          pad1_type = 0;
  int          pad2_type = 0;
  logic [11:0] btn1 = 12'h000;
  logic [11:0] btn2 = 12'h000;
  int          sel_falls = 0;
  int          sel_high_cycles = 0;
  logic        sel_prev = 1'b1;
  int          tests_run = 0;
  int          tests_failed = 0;

  sega_joy_scan #(.CLK_DIV(D)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .joy1_up_i(joy1_up_i), .joy1_down_i(joy1_down_i), .joy1_left_i(joy1_left_i),
    .joy1_right_i(joy1_right_i), .joy1_p6_i(joy1_p6_i), .joy1_p9_i(joy1_p9_i),
    .joy2_up_i(joy2_up_i), .joy2_down_i(joy2_down_i), .joy2_left_i(joy2_left_i),
    .joy2_right_i(joy2_right_i), .joy2_p6_i(joy2_p6_i), .joy2_p9_i(joy2_p9_i),
    .joyX_p7_o(joyX_p7_o), .joy1_o(joy1_o), .joy2_o(joy2_o),
    .six1_o(six1_o), .six2_o(six2_o), .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  // Pad pin model, returns {p9, p6, R, L, D, U} active-low for the current select level.
  function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] b,
                                          input logic sel, input int falls);
    if (typ == 0) return ~b[5:0];
    if (typ == 2 && falls == 3) begin
      if (sel) return ~{b[5], b[4], b[11], b[10], b[9], b[8]};
      return {~b[7], ~b[6], 4'b0000};
    end
    if (sel) return ~b[5:0];
    return {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
  endfunction

  assign {joy1_p9_i, joy1_p6_i, joy1_right_i, joy1_left_i, joy1_down_i, joy1_up_i} =
         pad_pins(pad1_type, btn1, joyX_p7_o, sel_falls);
  assign {joy2_p9_i, joy2_p6_i, joy2_right_i, joy2_left_i, joy2_down_i, joy2_up_i} =
         pad_pins(pad2_type, btn2, joyX_p7_o, sel_falls);

  // The pads count select falling edges and forget them once select idles high.
  always @(negedge clk_i) begin
    if (sel_prev && !joyX_p7_o) sel_falls = sel_falls + 1;
    if (joyX_p7_o) sel_high_cycles = sel_high_cycles + 1;
    else           sel_high_cycles = 0;
    if (sel_high_cycles > 2*D) sel_falls = 0;
    sel_prev = joyX_p7_o;
  end

  // Which buttons each pad type can report through the scanner.
  function automatic logic [11:0] model_word(input int typ, input logic [11:0] b);
    logic [11:0] visible;
    case (typ)
      0:       visible = 12'h03F;
      1:       visible = 12'h0FF;
      default: visible = SIX_EN ? 12'hFFF : 12'h0FF;
    endcase
    return ~(b & visible);
  endfunction

  function automatic logic model_six(input int typ);
    return (typ == 2) && SIX_EN;
  endfunction

  task automatic wait_frame(output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 300*D) begin
      @(posedge clk_i); #1;
      cycles++;
      if (frame_o) seen = 1'b1;
    end
  endtask

  task automatic settle(input string name);
    int c;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      wait_frame(c, seen);
      if (!seen) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL %s frame_timeout: no frame within %0d cycles", name, c);
      end
    end
  endtask

  task automatic test_reset();
    int   cyc;
    logic exp_sel;
    reset_i = 1'b1; pad1_type = 0; pad2_type = 0; btn1 = 12'h000; btn2 = 12'h000;
    repeat (20) @(posedge clk_i);
    #1;
    tests_run++;
    if (joyX_p7_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_p7: got %b expected 1", joyX_p7_o); end
    tests_run++;
    if ({joy1_o, joy2_o} !== 24'hFFFFFF) begin tests_failed++; $display("[TB] FAIL reset_words: got %h/%h expected fff/fff", joy1_o, joy2_o); end
    tests_run++;
    if ({six1_o, six2_o, frame_o} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {six1_o, six2_o, frame_o}); end
    @(negedge clk_i);
    reset_i = 1'b0;
    cyc = 0;
    while (cyc < 300*D) begin
      @(posedge clk_i); #1;
      cyc++;
      if (cyc % D == 0 && cyc <= 7*D) begin
        exp_sel = (((cyc / D) - 1) % 2) == 1;
        tests_run++;
        if (joyX_p7_o !== exp_sel) begin tests_failed++; $display("[TB] FAIL sel_phase%0d: got %b expected %b", cyc / D - 1, joyX_p7_o, exp_sel); end
      end
      if (frame_o) break;
    end
    tests_run++;
    if (cyc != 8*D) begin tests_failed++; $display("[TB] FAIL first_frame_latency: got %0d expected %0d", cyc, 8*D); end
    tests_run++;
    if ({joy1_o, joy2_o, six1_o, six2_o} !== {24'hFFFFFF, 2'b00}) begin
      tests_failed++; $display("[TB] FAIL idle_words: got %h/%h six %b%b expected fff/fff six 00", joy1_o, joy2_o, six1_o, six2_o);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bit seen;
    wait_frame(c, seen);
    tests_run++;
    if (!seen || c != 256*D) begin tests_failed++; $display("[TB] FAIL frame_period: got %0d expected %0d", c, 256*D); end
    @(posedge clk_i); #1;
    tests_run++;
    if (frame_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_width: got %b expected 0", frame_o); end
  endtask

  task automatic test_atari();
    pad1_type = 0; btn1 = 12'h011; pad2_type = 0; btn2 = 12'h000;
    settle("atari");
    tests_run++;
    if (joy1_o !== model_word(0, 12'h011)) begin tests_failed++; $display("[TB] FAIL atari_word: got %h expected %h", joy1_o, model_word(0, 12'h011)); end
    tests_run++;
    if (six1_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL atari_six: got %b expected 0", six1_o); end
    tests_run++;
    if (joy2_o !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL atari_port2: got %h expected fff", joy2_o); end
  endtask

  task automatic test_three_button();
    logic [11:0] exp_w;
    pad1_type = 0; btn1 = 12'h000; pad2_type = 1; btn2 = 12'h0C0;
    exp_w = model_word(1, 12'h0C0);
    settle("three");
    tests_run++;
    if (joy2_o[7:6] !== 2'b00) begin tests_failed++; $display("[TB] FAIL three_start_a: got %b expected 00", joy2_o[7:6]); end
    tests_run++;
    if (joy2_o !== exp_w) begin tests_failed++; $display("[TB] FAIL three_word: got %h expected %h", joy2_o, exp_w); end
    tests_run++;
    if (six2_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL three_six: got %b expected 0", six2_o); end
  endtask

  task automatic test_six_button();
    logic [11:0] exp_w;
    pad1_type = 2; btn1 = 12'h400; pad2_type = 0; btn2 = 12'h000;
    exp_w = model_word(2, 12'h400);
    settle("six");
    tests_run++;
    if (six1_o !== model_six(2)) begin tests_failed++; $display("[TB] FAIL six_flag: got %b expected %b", six1_o, model_six(2)); end
    tests_run++;
    if (joy1_o[11:8] !== exp_w[11:8]) begin tests_failed++; $display("[TB] FAIL six_xyzm: got %b expected %b", joy1_o[11:8], exp_w[11:8]); end
    tests_run++;
    if (joy1_o !== exp_w) begin tests_failed++; $display("[TB] FAIL six_word: got %h expected %h", joy1_o, exp_w); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    pad1_type = 1; btn1 = 12'h0C0; pad2_type = 0; btn2 = 12'h010;
    settle("midscan_pre");
    tests_run++;
    if (joy1_o !== 12'hF3F) begin tests_failed++; $display("[TB] FAIL midscan_pre_word: got %h expected f3f", joy1_o); end
    // Step into phase 5 of the following scan, where select is being held low.
    repeat (253*D + 2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    #1;
    tests_run++;
    if ({joy1_o, joy2_o} !== 24'hFFFFFF) begin tests_failed++; $display("[TB] FAIL midscan_words: got %h/%h expected fff/fff", joy1_o, joy2_o); end
    tests_run++;
    if ({joyX_p7_o, six1_o, six2_o, frame_o} !== 4'b1000) begin
      tests_failed++; $display("[TB] FAIL midscan_flags: got %b expected 1000", {joyX_p7_o, six1_o, six2_o, frame_o});
    end
    btn1 = 12'h000; btn2 = 12'h000;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    cyc = 0;
    while (cyc < 300*D) begin
      @(posedge clk_i); #1;
      cyc++;
      if (frame_o) break;
    end
    tests_run++;
    if (cyc != 8*D) begin tests_failed++; $display("[TB] FAIL midscan_frame_latency: got %0d expected %0d", cyc, 8*D); end
    tests_run++;
    if ({joy1_o, joy2_o} !== 24'hFFFFFF) begin tests_failed++; $display("[TB] FAIL midscan_fresh_words: got %h/%h expected fff/fff", joy1_o, joy2_o); end
  endtask

  task automatic test_random();
    logic [11:0] b1, b2, e1, e2;
    for (int it = 0; it < 12; it++) begin
      b1 = 12'($urandom());
      b2 = 12'($urandom());
      if (b1[0] && b1[1]) b1[1] = 1'b0;
      if (b1[2] && b1[3]) b1[3] = 1'b0;
      if (b2[0] && b2[1]) b2[1] = 1'b0;
      if (b2[2] && b2[3]) b2[3] = 1'b0;
      pad1_type = int'($urandom_range(0, 2));
      pad2_type = int'($urandom_range(0, 2));
      btn1 = b1; btn2 = b2;
      e1 = model_word(pad1_type, b1);
      e2 = model_word(pad2_type, b2);
      settle("random");
      tests_run++;
      if (joy1_o !== e1) begin tests_failed++; $display("[TB] FAIL rand%0d_joy1 type %0d btn %h: got %h expected %h", it, pad1_type, b1, joy1_o, e1); end
      tests_run++;
      if (joy2_o !== e2) begin tests_failed++; $display("[TB] FAIL rand%0d_joy2 type %0d btn %h: got %h expected %h", it, pad2_type, b2, joy2_o, e2); end
      tests_run++;
      if (six1_o !== model_six(pad1_type)) begin tests_failed++; $display("[TB] FAIL rand%0d_six1: got %b expected %b", it, six1_o, model_six(pad1_type)); end
      tests_run++;
      if (six2_o !== model_six(pad2_type)) begin tests_failed++; $display("[TB] FAIL rand%0d_six2: got %b expected %b", it, six2_o, model_six(pad2_type)); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_atari();
    test_three_button();
    test_six_button();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
